// File: rtl/sparce_sasa_ctrl_if.sv
// Bundle between the CSR/debug requesters, flush/enable/skip controls and the
// SASA table write port.
interface sparce_sasa_ctrl_if;
  logic        csr_req;
  logic [31:0] csr_addr;
  logic [31:0] csr_data;
  logic        csr_gnt;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_gnt;
  logic        flush_req;
  logic        enable_req;
  logic        skipping;
  logic [31:0] sasa_addr;
  logic [31:0] sasa_data;
  logic        sasa_wen;
  logic        sasa_enable;
  logic        busy;

  modport master (
    output csr_req, csr_addr, csr_data, dbg_req, dbg_addr, dbg_data,
           flush_req, enable_req, skipping,
    input  csr_gnt, dbg_gnt, sasa_addr, sasa_data, sasa_wen, sasa_enable, busy
  );

  modport slave (
    input  csr_req, csr_addr, csr_data, dbg_req, dbg_addr, dbg_data,
           flush_req, enable_req, skipping,
    output csr_gnt, dbg_gnt, sasa_addr, sasa_data, sasa_wen, sasa_enable, busy
  );
endinterface

// File: rtl/sparce_sasa_ctrl.sv
// SASA table configuration controller: round-robin CSR/debug write arbitration,
// hardware flush of every entry, and ownership of the table lookup enable.
//
// state | meaning
// IDLE  | no write issued last cycle; grants allowed
// WRITE | a granted write is on the table port; further grants allowed
// FLUSH | zeroing entries one per cycle; grants held off
module sparce_sasa_ctrl #(
  parameter int SASA_ENTRIES = 16,
  parameter int IDX_W        = $clog2(SASA_ENTRIES)
) (
  input logic               CLK,
  input logic               nRST,
  sparce_sasa_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_t;

  localparam int PAD_W = 30 - IDX_W;

  state_t           state_q;
  logic             rr_last_q;  // 1: debug was granted last
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic             wen_q;
  logic             en_q;

  logic can_grant_d;
  logic gnt_csr_d;
  logic gnt_dbg_d;

  assign can_grant_d = nRST && (state_q != FLUSH) && !bus.skipping && !bus.flush_req;
  assign gnt_csr_d   = can_grant_d && bus.csr_req && (!bus.dbg_req || rr_last_q);
  assign gnt_dbg_d   = can_grant_d && bus.dbg_req && (!bus.csr_req || !rr_last_q);

  assign bus.csr_gnt     = gnt_csr_d;
  assign bus.dbg_gnt     = gnt_dbg_d;
  assign bus.busy        = (state_q == FLUSH) || bus.csr_req || bus.dbg_req;
  assign bus.sasa_addr   = addr_q;
  assign bus.sasa_data   = data_q;
  assign bus.sasa_wen    = wen_q;
  assign bus.sasa_enable = en_q;

  function automatic logic [31:0] entry_addr(input logic [IDX_W-1:0] idx);
    return {{PAD_W{1'b0}}, idx, 2'b00};
  endfunction

  // The flush pulse cycle itself issues entry 0, so idx_q holds the next entry
  // to write; once it wraps back to zero the last entry is already out.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      idx_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wen_q     <= 1'b0;
      en_q      <= 1'b0;
    end else if (bus.flush_req) begin
      state_q <= FLUSH;
      idx_q   <= IDX_W'(1);
      addr_q  <= entry_addr('0);
      data_q  <= '0;
      wen_q   <= 1'b1;
      en_q    <= 1'b0;
    end else if (state_q == FLUSH) begin
      if (idx_q == '0) begin
        state_q <= IDLE;
        wen_q   <= 1'b0;
        en_q    <= bus.enable_req;
      end else begin
        idx_q  <= idx_q + 1'b1;
        addr_q <= entry_addr(idx_q);
        data_q <= '0;
        wen_q  <= 1'b1;
        en_q   <= 1'b0;
      end
    end else if (gnt_csr_d) begin
      state_q   <= WRITE;
      rr_last_q <= 1'b0;
      addr_q    <= bus.csr_addr;
      data_q    <= bus.csr_data;
      wen_q     <= 1'b1;
      en_q      <= bus.enable_req;
    end else if (gnt_dbg_d) begin
      state_q   <= WRITE;
      rr_last_q <= 1'b1;
      addr_q    <= bus.dbg_addr;
      data_q    <= bus.dbg_data;
      wen_q     <= 1'b1;
      en_q      <= bus.enable_req;
    end else begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      en_q    <= bus.enable_req;
    end
  end

endmodule

// File: tb/tb_sparce_sasa_ctrl.sv
// Bench for sparce_sasa_ctrl: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the table write stream.
module tb_sparce_sasa_ctrl;
  localparam int E = 16;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  sparce_sasa_ctrl_if bus();

  sparce_sasa_ctrl #(.SASA_ENTRIES(E)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: pending flush entries as a queue, flush hold-off as a
  // remaining-cycle count, and the expected table port for the next cycle.
  int          m_fq[$];
  int          m_block = 0;
  bit          m_rr_dbg = 1'b1;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_wen = 1'b0;
  bit          m_en = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_gc = 1'b0;
  bit          m_gd = 1'b0;
  int          wen_seen = 0;

  task automatic step(input bit rst_b,
                      input bit cr, input logic [31:0] ca, input logic [31:0] cd,
                      input bit dr, input logic [31:0] da, input logic [31:0] dd,
                      input bit fl, input bit en, input bit sk);
    bit blocked;
    @(negedge CLK);
    if (m_valid) begin
      check("sasa_wen", {31'b0, bus.sasa_wen}, {31'b0, m_wen});
      check("sasa_addr", bus.sasa_addr, m_addr);
      check("sasa_data", bus.sasa_data, m_data);
      check("sasa_enable", {31'b0, bus.sasa_enable}, {31'b0, m_en});
    end
    if (bus.sasa_wen === 1'b1) wen_seen++;
    nRST           = rst_b;
    bus.csr_req    = cr;
    bus.csr_addr   = ca;
    bus.csr_data   = cd;
    bus.dbg_req    = dr;
    bus.dbg_addr   = da;
    bus.dbg_data   = dd;
    bus.flush_req  = fl;
    bus.enable_req = en;
    bus.skipping   = sk;
    #1;
    blocked = !rst_b || (m_block > 0) || sk || fl;
    m_gc = 1'b0;
    m_gd = 1'b0;
    if (!blocked) begin
      if (cr && dr) begin
        if (m_rr_dbg) m_gc = 1'b1;
        else          m_gd = 1'b1;
      end else begin
        m_gc = cr;
        m_gd = dr;
      end
    end
    check("csr_gnt", {31'b0, bus.csr_gnt}, {31'b0, m_gc});
    check("dbg_gnt", {31'b0, bus.dbg_gnt}, {31'b0, m_gd});
    if (m_valid && rst_b)
      check("busy", {31'b0, bus.busy}, {31'b0, ((m_block > 0) || cr || dr)});

    if (!rst_b) begin
      m_fq.delete();
      m_block  = 0;
      m_rr_dbg = 1'b1;
      m_addr   = '0;
      m_data   = '0;
      m_wen    = 1'b0;
      m_en     = 1'b0;
    end else begin
      if (fl) begin
        m_fq.delete();
        for (int i = 0; i < E; i++) m_fq.push_back(i);
        m_block = E;
      end else if (m_block > 0) begin
        m_block--;
      end
      if (m_fq.size() > 0) begin
        m_addr = 32'(m_fq.pop_front() * 4);
        m_data = '0;
        m_wen  = 1'b1;
      end else if (m_gc) begin
        m_addr   = ca;
        m_data   = cd;
        m_wen    = 1'b1;
        m_rr_dbg = 1'b0;
      end else if (m_gd) begin
        m_addr   = da;
        m_data   = dd;
        m_wen    = 1'b1;
        m_rr_dbg = 1'b1;
      end else begin
        m_wen = 1'b0;
      end
      m_en = en && (m_block == 0);
    end
    m_valid = 1'b1;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, en, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          cr, dr, fl, en, sk, rb;
    logic [31:0] ca, cd, da, dd;
    int          waited;

    // Reset held with everything requesting, then the first tie goes to csr.
    step(0, 1, 32'h10, 32'h1111, 1, 32'h20, 32'h2222, 1, 1, 0);
    step(0, 1, 32'h10, 32'h1111, 1, 32'h20, 32'h2222, 1, 1, 0);
    step(1, 1, 32'h10, 32'h1111, 1, 32'h20, 32'h2222, 0, 0, 0);
    step(1, 0, 32'h0,  32'h0,    1, 32'h20, 32'h2222, 0, 0, 0);
    idle(2, 0);

    // Single CSR write.
    step(1, 1, 32'h8, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    idle(2, 0);

    // Contention for four cycles.
    for (int i = 0; i < 4; i++)
      step(1, 1, 32'h100 + 32'(i), 32'hC000 + 32'(i), 1, 32'h200 + 32'(i), 32'hD000 + 32'(i), 0, 1, 0);
    idle(2, 1);

    // Flush with a csr request raised mid-flush, held until granted.
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(6, 1);
    waited = 0;
    do begin
      step(1, 1, 32'h44, 32'h5A5A_0001, 0, 0, 0, 0, 1, 0);
      waited++;
    end while (!m_gc && waited < 40);
    check("mid_flush_csr_wait", 32'(waited), 32'(E - 6 + 1));
    idle(2, 1);

    // Skip hold-off with a pending debug write.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 32'h30, 32'hBEEF_0030, 0, 1, 1);
    step(1, 0, 0, 0, 1, 32'h30, 32'hBEEF_0030, 0, 1, 0);
    idle(2, 1);

    // Flush and csr together, then a restart at flush index 7.
    wen_seen = 0;
    step(1, 1, 32'h48, 32'h1234_5678, 0, 0, 0, 1, 1, 0);
    idle(6, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(E + 2, 1);
    check("restart_write_count", 32'(wen_seen), 32'd23);

    // Reset at flush index 3.
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(2, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    wen_seen = 0;
    idle(E + 2, 1);
    check("post_reset_writes", 32'(wen_seen), 32'd0);

    // Randomized traffic; requesters hold until granted.
    cr = 0; dr = 0; ca = 0; cd = 0; da = 0; dd = 0; en = 1;
    for (int t = 0; t < 3000; t++) begin
      if (!cr || m_gc) begin
        cr = ($urandom_range(0, 2) != 0);
        ca = $urandom;
        cd = $urandom;
      end
      if (!dr || m_gd) begin
        dr = ($urandom_range(0, 2) != 0);
        da = $urandom;
        dd = $urandom;
      end
      fl = ($urandom_range(0, 39) == 0);
      sk = ($urandom_range(0, 3) == 0);
      rb = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 15) == 0) en = ~en;
      step(rb, cr, ca, cd, dr, da, dd, fl, en, sk);
    end
    idle(2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
